// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing defaults and pattern-mode encodings for the VGA timing generator.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    typedef enum logic [1:0] {
        MODE_EXT   = 2'd0,
        MODE_SOLID = 2'd1,
        MODE_BARS  = 2'd2,
        MODE_CHECK = 2'd3
    } vga_mode_e;

endpackage

// File: rtl/vga_pattern.sv
// Combinational pixel colour for one stage-C+1 coordinate: external, solid, bars or checkerboard.
// Blanking forces black in every mode.
module vga_pattern
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int XW        = 10,
    parameter int YW        = 9,
    parameter int R_W       = 3,
    parameter int G_W       = 3,
    parameter int B_W       = 2,
    parameter int CHK_SHIFT = 4,
    parameter logic [R_W+G_W+B_W-1:0] SOLID_RGB = 8'hE0
) (
    input  vga_mode_e                mode,
    input  logic                     de,
    input  logic [XW-1:0]            x,
    input  logic [YW-1:0]            y,
    input  logic [R_W+G_W+B_W-1:0]   pix_in,
    output logic [R_W+G_W+B_W-1:0]   rgb
);

    localparam int BAR_W = H_ACTIVE / 8;

    int unsigned xi;
    int unsigned yi;
    logic [2:0]  bar;

    always_comb begin
        xi  = 32'(x);
        yi  = 32'(y);
        // columns past the last full bar stay in bar 7
        bar = 3'd7;
        if (xi < 32'(8 * BAR_W)) begin
            bar = 3'(xi / 32'(BAR_W));
        end
        rgb = '0;
        if (de) begin
            case (mode)
                MODE_EXT:   rgb = pix_in;
                MODE_SOLID: rgb = SOLID_RGB;
                MODE_BARS:  rgb = {{R_W{bar[2]}}, {G_W{bar[1]}}, {B_W{bar[0]}}};
                default:    rgb = ((((xi ^ yi) >> CHK_SHIFT) & 32'd1) != 32'd0) ? '1 : '0;
            endcase
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: h/v counters and pixel request at stage C, capture and pattern at C+1,
// registered sync/de/colour at C+2.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE  = H_ACTIVE_DEF,
    parameter int H_FP      = H_FP_DEF,
    parameter int H_SYNC    = H_SYNC_DEF,
    parameter int H_BP      = H_BP_DEF,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int V_FP      = V_FP_DEF,
    parameter int V_SYNC    = V_SYNC_DEF,
    parameter int V_BP      = V_BP_DEF,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int R_W       = 3,
    parameter int G_W       = 3,
    parameter int B_W       = 2,
    parameter int CHK_SHIFT = 4,
    parameter logic [R_W+G_W+B_W-1:0] SOLID_RGB = 8'hE0
) (
    input  logic                          app_clk,
    input  logic                          app_rst,
    input  logic                          en,
    input  logic [1:0]                    mode,
    output logic                          pix_req,
    output logic [$clog2(H_ACTIVE)-1:0]   pix_x,
    output logic [$clog2(V_ACTIVE)-1:0]   pix_y,
    input  logic [R_W+G_W+B_W-1:0]        pix_in,
    output logic                          hsync,
    output logic                          vsync,
    output logic                          de,
    output logic [R_W-1:0]                red,
    output logic [G_W-1:0]                green,
    output logic [B_W-1:0]                blue,
    output logic                          frame_start,
    output logic                          line_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int XW      = $clog2(H_ACTIVE);
    localparam int YW      = $clog2(V_ACTIVE);
    localparam int PW      = R_W + G_W + B_W;
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = HS_BEG + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = VS_BEG + V_SYNC;

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    vga_mode_e     mode_q, mode_d;
    logic          act_d, hs_d, vs_d, fs_d, ls_d;

    logic          de1_q, hs1_q, vs1_q, fs1_q, ls1_q;
    logic [XW-1:0] x1_q;
    logic [YW-1:0] y1_q;
    logic [PW-1:0] pix1_q;
    vga_mode_e     mode1_q;
    logic [PW-1:0] rgb_d;

    logic          hsync_q, vsync_q, de_q, fs_q, ls_q;
    logic [PW-1:0] rgb_q;

    always_comb begin
        act_d  = (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);
        hs_d   = (int'(h_cnt_q) >= HS_BEG && int'(h_cnt_q) < HS_END) ? HS_POL : ~HS_POL;
        vs_d   = (int'(v_cnt_q) >= VS_BEG && int'(v_cnt_q) < VS_END) ? VS_POL : ~VS_POL;
        fs_d   = (h_cnt_q == '0) && (v_cnt_q == '0);
        ls_d   = (h_cnt_q == '0) && (int'(v_cnt_q) < V_ACTIVE);
        // mode only changes at the frame boundary, and that first pixel already uses it
        mode_d = fs_d ? vga_mode_e'(mode) : mode_q;

        h_cnt_d = h_cnt_q + HW'(1);
        v_cnt_d = v_cnt_q;
        if (int'(h_cnt_q) == H_TOTAL - 1) begin
            h_cnt_d = '0;
            v_cnt_d = (int'(v_cnt_q) == V_TOTAL - 1) ? '0 : v_cnt_q + VW'(1);
        end

        // request is suppressed while reset is held so the zeroed counters do not leak out
        pix_req = act_d & ~app_rst;
        pix_x   = pix_req ? h_cnt_q[XW-1:0] : '0;
        pix_y   = pix_req ? v_cnt_q[YW-1:0] : '0;
    end

    vga_pattern #(
        .H_ACTIVE  (H_ACTIVE),
        .XW        (XW),
        .YW        (YW),
        .R_W       (R_W),
        .G_W       (G_W),
        .B_W       (B_W),
        .CHK_SHIFT (CHK_SHIFT),
        .SOLID_RGB (SOLID_RGB)
    ) u_pattern (
        .mode   (mode1_q),
        .de     (de1_q),
        .x      (x1_q),
        .y      (y1_q),
        .pix_in (pix1_q),
        .rgb    (rgb_d)
    );

    always_ff @(posedge app_clk) begin
        if (app_rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            mode_q  <= MODE_SOLID;
            de1_q   <= 1'b0;
            hs1_q   <= ~HS_POL;
            vs1_q   <= ~VS_POL;
            fs1_q   <= 1'b0;
            ls1_q   <= 1'b0;
            x1_q    <= '0;
            y1_q    <= '0;
            pix1_q  <= '0;
            mode1_q <= MODE_SOLID;
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            de_q    <= 1'b0;
            fs_q    <= 1'b0;
            ls_q    <= 1'b0;
            rgb_q   <= '0;
        end else if (en) begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            mode_q  <= mode_d;
            de1_q   <= act_d;
            hs1_q   <= hs_d;
            vs1_q   <= vs_d;
            fs1_q   <= fs_d;
            ls1_q   <= ls_d;
            x1_q    <= h_cnt_q[XW-1:0];
            y1_q    <= v_cnt_q[YW-1:0];
            pix1_q  <= pix_in;
            mode1_q <= mode_d;
            hsync_q <= hs1_q;
            vsync_q <= vs1_q;
            de_q    <= de1_q;
            fs_q    <= fs1_q;
            ls_q    <= ls1_q;
            rgb_q   <= rgb_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign frame_start = fs_q;
    assign line_start  = ls_q;
    assign red         = rgb_q[PW-1 -: R_W];
    assign green       = rgb_q[B_W +: G_W];
    assign blue        = rgb_q[B_W-1:0];

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameter H_FP, 16, horizontal front porch in clocks.
REQ-003 Parameter H_SYNC, 96, hsync pulse width in clocks.
REQ-004 Parameter H_BP, 48, horizontal back porch in clocks.
REQ-005 Parameters V_ACTIVE/V_FP/V_SYNC/V_BP, 480/10/2/33, vertical equivalents in lines.
REQ-006 Parameters HS_POL/VS_POL, 0/0, sync asserted level (0 = active low).
REQ-007 Parameters R_W/G_W/B_W, 3/3/2, colour channel widths.
REQ-008 Parameter CHK_SHIFT, 4, checkerboard square size = 2^CHK_SHIFT pixels.
REQ-009 Parameter SOLID_RGB, 8'hE0, solid-mode colour, packed {R,G,B}.
REQ-010 app_clk  in  1  pixel clock; the block uses one clock only.
REQ-011 app_rst  in  1  reset, synchronous and active-high.
REQ-012 en  in  1  count enable; low freezes all state.
REQ-013 mode  in  2  0 external, 1 solid, 2 colour bars, 3 checkerboard.
REQ-014 pix_req  out  1  external pixel request, high in active area (stage C).
REQ-015 pix_x / pix_y  out  clog2(H_ACTIVE) / clog2(V_ACTIVE)  requested coordinate (stage C).
REQ-016 pix_in  in  R_W+G_W+B_W  external pixel, sampled at C+1.
REQ-017 hsync / vsync / de  out  1 each  timing outputs (C+2).
REQ-018 red / green / blue  out  R_W / G_W / B_W  colour outputs (C+2).
REQ-019 frame_start / line_start  out  1 each  one-clock pulses at first active pixel of frame / of each active line (C+2).

Function
REQ-020 h_cnt counts 0..H_TOTAL-1 (H_TOTAL = sum of H params), wraps to 0; v_cnt increments when h_cnt wraps, counts 0..V_TOTAL-1, wraps to 0.
REQ-021 Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE; active area starts at count 0.
REQ-022 hsync asserted (HS_POL) for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vsync likewise on v_cnt; deasserted otherwise.
REQ-023 Pipeline: stage C = counters, pix_req/x/y; C+1 = pix_in capture and pattern generation; C+2 = registered outputs; all C+2 outputs aligned to the same counter value.
REQ-024 pix_x/pix_y equal h_cnt/v_cnt when pix_req high; held at 0 when pix_req low.
REQ-025 mode is sampled only at h_cnt==0 and v_cnt==0 (frame boundary); mid-frame changes take effect next frame.
REQ-026 Mode 2: 8 equal vertical bars, width H_ACTIVE/8 (integer); bar k colour bits {k[2] to R MSBs, k[1] to G MSBs, k[0] to B MSBs} replicated to full width; pixels beyond 8*(H_ACTIVE/8) use bar 7.
REQ-027 Mode 3: white when x[CHK_SHIFT]^y[CHK_SHIFT] = 1, else black.
REQ-028 red/green/blue are forced to 0 whenever de is low, in every mode.
REQ-029 en low: counters, pipeline registers and outputs hold their values; resuming continues without a glitch or skipped count.
REQ-030 Parameter sums are fixed at elaboration; counter widths = clog2(H_TOTAL), clog2(V_TOTAL).

Reset
REQ-031 On app_rst high at a clock edge: h_cnt=v_cnt=0, latched mode=1 (solid), pipeline cleared.
REQ-032 Reset values: hsync=~HS_POL, vsync=~VS_POL, de=0, rgb=0, pix_req=0, pix_x=pix_y=0, frame_start=line_start=0.
REQ-033 Reset mid-frame aborts the frame; first cycle after release is h_cnt=v_cnt=0 at stage C, and frame_start fires 2 clocks later.

Structure
REQ-034 Default 640x480@60 timing constants and mode encodings live in shared package vga_pkg.
REQ-035 Pattern generation (modes 1-3, blanking) is sub-module vga_pattern; counters/sync stay in vga_timing_gen.

Verification
REQ-036 Small params H 8/2/2/4, V 4/1/1/2, HS_POL=VS_POL=0: hsync low exactly clocks 10-11 of each 16-clock line; vsync low lines 5; frame period 128 clocks.
REQ-037 Defaults, mode 0, pix_in = pix_x[7:0] looped back: red/green/blue at C+2 equal that x; de high 640 clocks per line, 480 lines per frame.
REQ-038 mode changed 1->3 mid-frame: output stays SOLID_RGB until next frame_start, then checkerboard (x=16,y=0 white; x=0,y=0 black).
REQ-039 en held low 5 clocks mid-line: all outputs frozen 5 clocks; total frame period extends by exactly 5.
REQ-040 app_rst pulsed at v_cnt=200: outputs take REQ-032 values next edge; frame_start asserts 2 clocks after release.
REQ-041 Mode 2 defaults: x=0 black, x=80 blue (2'b11), x=639 white; rgb=0 during blanking.
